// File: rtl/ramp_pkg.sv
// Shared constants and types for the ramp_mem storage block.
// Defaults give a 128 x 16-bit single-port RAM.
package ramp_pkg;

  localparam int RAMP_R = 7;
  localparam int RAMP_W = 4;

  localparam int RAMP_DW    = 2 ** RAMP_W;
  localparam int RAMP_DEPTH = 2 ** RAMP_R;

  typedef logic [RAMP_DW-1:0] ramp_word_t;

endpackage

// File: rtl/ramp_mem.sv
// Single-port RAM with registered read data.
// Active-low async reset clears the whole array and d_out.
module ramp_mem
  import ramp_pkg::*;
#(
  parameter int R = RAMP_R,
  parameter int W = RAMP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_rd,
  input  logic [R-1:0]    addr,
  input  logic [2**W-1:0] d_in,
  output logic [2**W-1:0] d_out
);

  localparam int DW    = 2 ** W;
  localparam int DEPTH = 2 ** R;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] dout_q;
  logic [DW-1:0] dout_d;

  always_comb begin
    mem_d  = mem_q;
    dout_d = dout_q;
    unique case (1'b1)
      wr_rd:  mem_d[addr] = d_in;
      !wr_rd: dout_d = mem_q[addr];
      default: ;
    endcase
  end

  // Array is plain flops so the whole store can clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '{default: '0};
      dout_q <= '0;
    end else begin
      mem_q  <= mem_d;
      dout_q <= dout_d;
    end
  end

  assign d_out = dout_q;

endmodule

// File: tb/tb_ramp_mem.sv
// Directed self-checking bench for ramp_mem.
// Expected data comes from a local shadow array.
module tb_ramp_mem;
  import ramp_pkg::*;

  logic       clk;
  logic       rst;
  logic       wr_rd;
  logic [6:0] addr;
  ramp_word_t d_in;
  ramp_word_t d_out;

  ramp_word_t exp_mem [128];

  int n_checks;
  int n_errors;

  ramp_mem #(.R(7), .W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_rd (wr_rd),
    .addr  (addr),
    .d_in  (d_in),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input ramp_word_t obs,
    input ramp_word_t exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input ramp_word_t v);
    wr_rd = 1'b1;
    addr  = 7'(a);
    d_in  = v;
    step();
  endtask

  task automatic rd(input int a);
    wr_rd = 1'b0;
    addr  = 7'(a);
    d_in  = '0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b0;
    wr_rd = 1'b1;
    addr  = 7'd9;
    d_in  = 16'hBEEF;

    step();
    step();
    chk("reset_dout", d_out, 16'h0000);

    rst = 1'b1;
    rd(0);
    chk("rst_rd0", d_out, 16'h0000);
    rd(5);
    chk("rst_rd5", d_out, 16'h0000);
    rd(127);
    chk("rst_rd127", d_out, 16'h0000);

    for (int i = 0; i < 128; i++) begin
      exp_mem[i] = 16'($urandom);
      if (i == 3) exp_mem[i] = 16'hA5C3;
      wr(i, exp_mem[i]);
    end
    for (int i = 0; i < 128; i++) begin
      rd(i);
      chk($sformatf("sweep_%0d", i), d_out, exp_mem[i]);
    end

    wr(10, 16'h1234);
    rd(10);
    chk("hold_rd10", d_out, 16'h1234);
    wr(11, 16'hFFFF);
    chk("hold_wr11", d_out, 16'h1234);
    rd(11);
    chk("rd11", d_out, 16'hFFFF);

    wr(127, 16'h0001);
    rd(127);
    chk("raw_127", d_out, 16'h0001);

    wr(0, 16'h0000);
    wr(127, 16'hFFFF);
    rd(0);
    chk("bnd_a0_zero", d_out, 16'h0000);
    rd(127);
    chk("bnd_a127_ones", d_out, 16'hFFFF);
    wr(0, 16'hFFFF);
    wr(127, 16'h0000);
    rd(0);
    chk("bnd_a0_ones", d_out, 16'hFFFF);
    rd(127);
    chk("bnd_a127_zero", d_out, 16'h0000);

    wr(0, 16'h1111);
    wr(1, 16'h2222);
    wr(2, 16'h3333);
    wr(3, 16'h4444);
    rd(2);
    chk("pre_rst_rd2", d_out, 16'h3333);
    wr_rd = 1'b1;
    addr  = 7'd1;
    d_in  = 16'h5A5A;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_dout", d_out, 16'h0000);
    step();
    chk("mid_rst_hold", d_out, 16'h0000);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(i);
      chk($sformatf("post_rst_%0d", i), d_out, 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
